// File: rtl/i2s_pkg.sv
// Shared I2S definitions: sample/frame widths, stereo frame type and the
// load-time formatter used by the sample feeder.
package i2s_pkg;

  localparam int SAMPLE_W      = 32;
  localparam int FRAME_W       = 2 * SAMPLE_W;
  localparam int DEFAULT_DEPTH = 8;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } frame_t;

  // Sign-extending attenuation of both channels; mute forces silence.
  function automatic frame_t format_frame(input frame_t f, input logic [4:0] shift,
                                          input logic mute);
    frame_t r;
    r.left  = mute ? '0 : $unsigned($signed(f.left) >>> shift);
    r.right = mute ? '0 : $unsigned($signed(f.right) >>> shift);
    return r;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Single-clock DEPTH x frame FIFO; pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate counter.
module sample_fifo
  import i2s_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  frame_t                   push_data,
  input  logic                     pop,
  output frame_t                   head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  frame_t        mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == LW'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/i2s_sample_feeder.sv
// Stereo sample buffer ahead of the I2S transmitter: FIFO, pop edge detect,
// formatted presentation register and saturating underrun counter.
module i2s_sample_feeder
  import i2s_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = 16
) (
  input  logic                    sclk,
  input  logic                    aclr,
  // Handshake: a frame transfers on a rising edge where in_valid && in_ready.
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SAMPLE_W-1:0]     in_left,
  input  logic [SAMPLE_W-1:0]     in_right,
  input  logic [4:0]              atten,
  input  logic                    mute,
  input  logic                    tx_ready,
  output logic [FRAME_W-1:0]      sample,
  output logic                    sample_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_W-1:0]        underrun_count,
  input  logic                    clear_underrun
);

  logic   tx_ready_q;
  logic   pop_evt;
  logic   push;
  logic   load_head;
  logic   fifo_full;
  logic   fifo_empty;
  frame_t head;
  frame_t sample_q;

  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;
  assign pop_evt   = tx_ready && !tx_ready_q;
  // Load on a pop, or refill an idle presentation register, whenever data exists.
  assign load_head = !fifo_empty && (pop_evt || !sample_ready);
  assign sample    = sample_q;

  sample_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (sclk),
    .rst       (aclr),
    .push      (push),
    .push_data ({in_left, in_right}),
    .pop       (load_head),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  // Resetting to 1 hides a tx_ready still held high out of the transmitter's reset.
  always_ff @(posedge sclk) begin
    if (aclr) tx_ready_q <= 1'b1;
    else      tx_ready_q <= tx_ready;
  end

  always_ff @(posedge sclk) begin
    if (aclr) begin
      sample_q     <= '0;
      sample_ready <= 1'b0;
    end else if (load_head) begin
      sample_q     <= format_frame(head, atten, mute);
      sample_ready <= 1'b1;
    end else if (pop_evt) begin
      sample_q     <= '0;
      sample_ready <= 1'b0;
    end
  end

  always_ff @(posedge sclk) begin
    if (aclr || clear_underrun) begin
      underrun_count <= '0;
    end else if (pop_evt && fifo_empty && (underrun_count != '1)) begin
      underrun_count <= underrun_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_i2s_sample_feeder.sv
// Directed bench for i2s_sample_feeder with a frame scoreboard; a second
// narrow-counter instance exercises underrun saturation quickly.
module tb_i2s_sample_feeder;
  import i2s_pkg::*;

  localparam int DEPTH = 8;

  logic        sclk = 1'b0;
  logic        aclr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_left;
  logic [31:0] in_right;
  logic [4:0]  atten;
  logic        mute;
  logic        tx_ready;
  logic [63:0] sample;
  logic        sample_ready;
  logic [3:0]  level;
  logic [15:0] underrun_count;
  logic        clear_underrun;

  logic        sat_tx_ready;
  logic        sat_clear;
  logic        sat_in_valid;
  logic [31:0] sat_word;
  logic        sat_in_ready;
  logic [63:0] sat_sample;
  logic        sat_sample_ready;
  logic [1:0]  sat_level;
  logic [3:0]  sat_count;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];

  always #5 sclk = ~sclk;

  i2s_sample_feeder #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .sclk           (sclk),
    .aclr           (aclr),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_left        (in_left),
    .in_right       (in_right),
    .atten          (atten),
    .mute           (mute),
    .tx_ready       (tx_ready),
    .sample         (sample),
    .sample_ready   (sample_ready),
    .level          (level),
    .underrun_count (underrun_count),
    .clear_underrun (clear_underrun)
  );

  i2s_sample_feeder #(.DEPTH(2), .CNT_W(4)) u_sat (
    .sclk           (sclk),
    .aclr           (aclr),
    .in_valid       (sat_in_valid),
    .in_ready       (sat_in_ready),
    .in_left        (sat_word),
    .in_right       (sat_word),
    .atten          (5'd0),
    .mute           (1'b0),
    .tx_ready       (sat_tx_ready),
    .sample         (sat_sample),
    .sample_ready   (sat_sample_ready),
    .level          (sat_level),
    .underrun_count (sat_count),
    .clear_underrun (sat_clear)
  );

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference formatter: repeated one-bit sign-filling shifts.
  function automatic logic [63:0] model_fmt(input logic [31:0] l, input logic [31:0] r,
                                            input logic [4:0] a, input logic m);
    logic [31:0] lw;
    logic [31:0] rw;
    lw = l;
    rw = r;
    for (int i = 0; i < int'(a); i++) begin
      lw = {lw[31], lw[31:1]};
      rw = {rw[31], rw[31:1]};
    end
    if (m) return 64'd0;
    return {lw, rw};
  endfunction

  function automatic logic [63:0] next_exp();
    if (exp_q.size() == 0) return 64'hx;
    return exp_q.pop_front();
  endfunction

  task automatic push_frame(input logic [31:0] l, input logic [31:0] r);
    in_valid = 1'b1;
    in_left  = l;
    in_right = r;
    if (in_ready) exp_q.push_back(model_fmt(l, r, atten, mute));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_pulse();
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    tick();
  endtask

  task automatic pop_check(input string tag, input logic [3:0] exp_level);
    tx_ready = 1'b1;
    tick();
    check({tag, "_sample"}, sample, next_exp());
    check({tag, "_ready"}, 64'(sample_ready), 64'd1);
    check({tag, "_level"}, 64'(level), 64'(exp_level));
    tx_ready = 1'b0;
    tick();
  endtask

  initial begin
    aclr = 1'b1; tx_ready = 1'b1; in_valid = 1'b0; in_left = '0; in_right = '0;
    atten = '0; mute = 1'b0; clear_underrun = 1'b0;
    sat_tx_ready = 1'b0; sat_clear = 1'b0; sat_in_valid = 1'b0; sat_word = '0;
    repeat (3) tick();
    aclr = 1'b0;
    tick();
    // tx_ready held high across reset release must not count as a pop
    check("rst_sample", sample, 64'd0);
    check("rst_ready", 64'(sample_ready), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_underrun", 64'(underrun_count), 64'd0);
    tx_ready = 1'b0;
    tick();

    // Underrun pops on an empty block
    tx_ready = 1'b1;
    tick();
    check("ur1_sample", sample, 64'd0);
    check("ur1_ready", 64'(sample_ready), 64'd0);
    check("ur1_count", 64'(underrun_count), 64'd1);
    tx_ready = 1'b0;
    tick();
    pop_pulse();
    check("ur2_count", 64'(underrun_count), 64'd2);

    // Attenuated push-to-present latency
    atten = 5'd1;
    push_frame(32'h4000_0000, 32'hC000_0000);
    check("lat_level1", 64'(level), 64'd1);
    check("lat_ready_n", 64'(sample_ready), 64'd0);
    tick();
    check("lat_sample", sample, 64'h2000_0000_E000_0000);
    check("lat_ready", 64'(sample_ready), 64'd1);
    check("lat_level0", 64'(level), 64'd0);
    exp_q.delete();

    // Empty the presentation register, then overfill
    atten = 5'd0;
    pop_pulse();
    check("ur3_count", 64'(underrun_count), 64'd3);
    for (int i = 0; i < 9; i++) push_frame($urandom, $urandom);
    check("full_level", 64'(level), 64'd8);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_head", sample, next_exp());
    push_frame(32'hDEAD_BEEF, 32'h0BAD_F00D);
    check("full_reject_level", 64'(level), 64'd8);

    // tx_ready held 3 cycles: exactly one pop
    tx_ready = 1'b1;
    tick();
    check("hold_sample", sample, next_exp());
    check("hold_level_a", 64'(level), 64'd7);
    tick();
    tick();
    check("hold_level_b", 64'(level), 64'd7);
    check("hold_in_ready", 64'(in_ready), 64'd1);
    tx_ready = 1'b0;
    tick();
    for (int k = 6; k >= 0; k--) pop_check($sformatf("drain%0d", k), 4'(k));
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_count", 64'(underrun_count), 64'd3);

    // Push coinciding with a pop on an empty FIFO
    in_valid = 1'b1; in_left = 32'h8000_0001; in_right = 32'h7FFF_FFFE;
    atten = 5'd3;
    tx_ready = 1'b1;
    tick();
    in_valid = 1'b0; tx_ready = 1'b0;
    check("co_sample", sample, 64'd0);
    check("co_ready", 64'(sample_ready), 64'd0);
    check("co_count", 64'(underrun_count), 64'd4);
    check("co_level", 64'(level), 64'd1);
    tick();
    check("co_refill", sample, model_fmt(32'h8000_0001, 32'h7FFF_FFFE, 5'd3, 1'b0));
    check("co_refill_ready", 64'(sample_ready), 64'd1);

    // Mute sampled at load; later atten/mute changes do not alter a held frame
    pop_pulse();
    mute = 1'b1;
    push_frame(32'h1234_5678, 32'h9ABC_DEF0);
    tick();
    check("mute_sample", sample, 64'd0);
    check("mute_ready", 64'(sample_ready), 64'd1);
    mute = 1'b0; atten = 5'd4;
    tick();
    check("mute_hold", sample, 64'd0);
    exp_q.delete();

    // Clear wins over a simultaneous underrun increment
    check("pre_clear_count", 64'(underrun_count), 64'd5);
    clear_underrun = 1'b1; tx_ready = 1'b1;
    tick();
    clear_underrun = 1'b0; tx_ready = 1'b0;
    check("clear_count", 64'(underrun_count), 64'd0);
    check("clear_ready", 64'(sample_ready), 64'd0);
    tick();

    // Reset mid-operation discards buffered and presented data
    atten = 5'd0;
    push_frame(32'h1111_1111, 32'h2222_2222);
    push_frame(32'h3333_3333, 32'h4444_4444);
    push_frame(32'h5555_5555, 32'h6666_6666);
    check("mid_level", 64'(level), 64'd2);
    aclr = 1'b1;
    tick();
    aclr = 1'b0;
    exp_q.delete();
    check("mid_rst_level", 64'(level), 64'd0);
    check("mid_rst_sample", sample, 64'd0);
    check("mid_rst_ready", 64'(sample_ready), 64'd0);
    tick();
    check("mid_rst_no_refill", 64'(sample_ready), 64'd0);

    // Saturation on the narrow-counter instance
    for (int i = 0; i < 15; i++) begin
      sat_tx_ready = 1'b1;
      tick();
      sat_tx_ready = 1'b0;
      tick();
    end
    check("sat_max", 64'(sat_count), 64'd15);
    sat_tx_ready = 1'b1;
    tick();
    sat_tx_ready = 1'b0;
    check("sat_hold", 64'(sat_count), 64'd15);
    tick();
    sat_clear = 1'b1; sat_tx_ready = 1'b1;
    tick();
    sat_clear = 1'b0; sat_tx_ready = 1'b0;
    check("sat_clear", 64'(sat_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
